// File: rtl/disp_arbiter_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
// Optional blink feature is selected by DISP_BLINK_EN in disp_arbiter.
package disp_pkg;

  localparam int VALUE_W = 6;

  typedef enum logic [1:0] {
    SRC_SCORE = 2'd0,
    SRC_TIMER = 2'd1,
    SRC_FLASH = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    SCORE,
    TIMER,
    FLASH
  } disp_state_e;

  // Counter width large enough to hold any value up to and including v.
  function automatic int cnt_width(input int v);
    return $clog2(v) + 1;
  endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// Display arbiter bus: game-side sources in, decoder-side value/blank out.
interface disp_arbiter_if;
  import disp_pkg::*;

  logic               display_en;
  logic [VALUE_W-1:0] score_value;
  logic               timer_active;
  logic [VALUE_W-1:0] timer_value;
  logic               flash_req;
  logic [VALUE_W-1:0] flash_value;
  logic [VALUE_W-1:0] result_data;
  logic               blank;
  logic [1:0]         src;
  logic               flash_busy;

  modport master (
    output display_en, score_value, timer_active, timer_value, flash_req, flash_value,
    input  result_data, blank, src, flash_busy
  );

  modport slave (
    input  display_en, score_value, timer_active, timer_value, flash_req, flash_value,
    output result_data, blank, src, flash_busy
  );

endinterface

// File: rtl/disp_hold_timer.sv
// Loadable down-counter that stops at zero; zero flags the final cycle of a hold.
module disp_hold_timer
  import disp_pkg::*;
#(
  parameter int  MAX_VAL = 1,
  localparam int W       = cnt_width(MAX_VAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/disp_arbiter.sv
// Chooses score, countdown or held flash message for the two-digit display.
// Define DISP_BLINK_EN to blink the flash message instead of showing it steadily.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input logic           clk,
  input logic           reset,
  disp_arbiter_if.slave bus
);

  localparam int HOLD_W  = cnt_width(HOLD_CYCLES);

  if (HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
    $error("disp_arbiter: HOLD_CYCLES and BLINK_CYCLES must be >= 1");
  end

  disp_state_e        state;
  logic [VALUE_W-1:0] flash_val;
  logic               hold_zero;
  logic               flash_stay;
  logic               blink_phase_nxt;

  // Remain in FLASH only while the hold has not expired and no new request arrives.
  assign flash_stay = !bus.flash_req && (state == FLASH) && !hold_zero;

  disp_hold_timer #(.MAX_VAL(HOLD_CYCLES)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (bus.flash_req),
    .load_val (HOLD_W'(HOLD_CYCLES - 1)),
    .enable   (state == FLASH),
    .zero     (hold_zero)
  );

`ifdef DISP_BLINK_EN
  localparam int BLINK_W = cnt_width(BLINK_CYCLES);

  logic blink_zero;
  logic blink_phase;

  disp_hold_timer #(.MAX_VAL(BLINK_CYCLES)) u_blink (
    .clk      (clk),
    .reset    (reset),
    .load     (bus.flash_req || (flash_stay && blink_zero)),
    .load_val (BLINK_W'(BLINK_CYCLES - 1)),
    .enable   (flash_stay),
    .zero     (blink_zero)
  );

  always_comb begin
    blink_phase_nxt = 1'b0;
    if (flash_stay) begin
      blink_phase_nxt = blink_phase ^ blink_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_phase <= 1'b0;
    end else begin
      blink_phase <= blink_phase_nxt;
    end
  end
`else
  assign blink_phase_nxt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SCORE;
      flash_val      <= '0;
      bus.result_data <= '0;
      bus.blank      <= 1'b1;
      bus.src        <= SRC_SCORE;
      bus.flash_busy <= 1'b0;
    end else begin
      bus.blank <= ~bus.display_en | blink_phase_nxt;
      if (bus.flash_req) begin
        state           <= FLASH;
        flash_val       <= bus.flash_value;
        bus.result_data <= bus.flash_value;
        bus.src         <= SRC_FLASH;
        bus.flash_busy  <= 1'b1;
      end else if (flash_stay) begin
        state           <= FLASH;
        bus.result_data <= flash_val;
        bus.src         <= SRC_FLASH;
        bus.flash_busy  <= 1'b1;
      end else if (bus.timer_active) begin
        state           <= TIMER;
        bus.result_data <= bus.timer_value;
        bus.src         <= SRC_TIMER;
        bus.flash_busy  <= 1'b0;
      end else begin
        state           <= SCORE;
        bus.result_data <= bus.score_value;
        bus.src         <= SRC_SCORE;
        bus.flash_busy  <= 1'b0;
      end
    end
  end

endmodule
